// File: rtl/pixel_stream_writer_pkg.sv
// Shared raster types: writer FSM states, write-FIFO entry, default screen size.
// Latency/backpressure: none (types and constants only).
package raster_pkg;

    localparam int DEF_H_RES  = 320;
    localparam int DEF_V_RES  = 180;
    localparam int FB_ADDR_W  = $clog2(DEF_H_RES * DEF_V_RES);
    localparam int FB_COLOR_W = 8;

    typedef enum logic [1:0] {IDLE, ACCEPT, DRAIN, DONE} state_t;

    // Entry widths follow the shared screen constants; widen these for larger screens.
    typedef struct packed {
        logic [FB_ADDR_W-1:0]  addr;
        logic [FB_COLOR_W-1:0] color;
    } fifo_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pixel_stream_writer_if.sv
// Pixel stream from the fill blocks and the framebuffer write port.
// Latency/backpressure: oe throttles the pixel stream; fb_ready stalls framebuffer writes.
interface pixel_stream_if #(parameter int COORD_WIDTH = 16);
    logic signed [COORD_WIDTH-1:0] x_in;
    logic signed [COORD_WIDTH-1:0] y_in;
    logic                          drawing_in;
    logic                          done_in;
    logic                          oe;

    modport master (output x_in, y_in, drawing_in, done_in, input  oe);
    modport slave  (input  x_in, y_in, drawing_in, done_in, output oe);
endinterface

interface fb_write_if #(parameter int ADDR_WIDTH = 16, parameter int COLOR_WIDTH = 8);
    logic [ADDR_WIDTH-1:0]  fb_addr;
    logic [COLOR_WIDTH-1:0] fb_data;
    logic                   fb_we;
    logic                   fb_ready;

    modport master (output fb_addr, fb_data, fb_we, input  fb_ready);
    modport slave  (input  fb_addr, fb_data, fb_we, output fb_ready);
endinterface

// File: rtl/pixel_stream_writer_sync_fifo.sv
// Synchronous FIFO with occupancy count; head is visible on dout while not empty.
// Latency: push visible next cycle; push to full is refused unless a pop frees a slot.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && full && !pop));
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pixel_stream_writer.sv
// Clips raster pixels, linearises to framebuffer addresses and queues writes; PIXEL_STATS_EN adds counters.
// Latency: pixel to fb_we in 2 cycles; oe drops with 2-cycle producer slack, fb_ready stalls the FIFO head.
module pixel_stream_writer
    import raster_pkg::*;
#(
    parameter int COORD_WIDTH = 16,
    parameter int H_RES       = DEF_H_RES,
    parameter int V_RES       = DEF_V_RES,
    parameter int COLOR_WIDTH = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int ADDR_WIDTH  = $clog2(H_RES * V_RES)
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   start,
    input  logic [COLOR_WIDTH-1:0] color_in,
    pixel_stream_if.slave          pix,
    fb_write_if.master             fb,
    output logic                   busy,
    output logic                   done
`ifdef PIXEL_STATS_EN
    ,
    output logic [31:0]            stat_written,
    output logic [31:0]            stat_clipped,
    output logic [31:0]            stat_stall
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = 2 * COORD_WIDTH;
    localparam logic signed [COORD_WIDTH-1:0] X_LIM = COORD_WIDTH'(H_RES);
    localparam logic signed [COORD_WIDTH-1:0] Y_LIM = COORD_WIDTH'(V_RES);

    state_t                 state;
    state_t                 state_nxt;
    logic [COLOR_WIDTH-1:0] color_q;
    logic                   s1_vld;
    logic [ADDR_WIDTH-1:0]  s1_addr;
    logic                   start_acc;
    logic                   take;
    logic                   in_range;
    logic [PW-1:0]          lin_addr;
    fifo_entry_t            push_entry;
    fifo_entry_t            head;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   pop;
    logic [CW-1:0]          fifo_count;
    logic [CW-1:0]          occ;

    assign start_acc = (state == IDLE) && start;
    assign take      = (state == ACCEPT) && pix.drawing_in;
    assign in_range  = !pix.x_in[COORD_WIDTH-1] && (pix.x_in < X_LIM) &&
                       !pix.y_in[COORD_WIDTH-1] && (pix.y_in < Y_LIM);
    assign lin_addr  = PW'($unsigned(pix.y_in)) * PW'(H_RES) + PW'($unsigned(pix.x_in));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_vld  <= 1'b0;
            s1_addr <= '0;
            color_q <= '0;
        end else begin
            s1_vld <= take && in_range;
            if (take && in_range) s1_addr <= lin_addr[ADDR_WIDTH-1:0];
            if (start_acc)        color_q <= color_in;
        end
    end

    always_comb begin
        push_entry       = '0;
        push_entry.addr  = FB_ADDR_W'(s1_addr);
        push_entry.color = FB_COLOR_W'(color_q);
    end

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (s1_vld),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Gate the head so the port reads zero while the FIFO is empty (memory is not reset).
    assign fb.fb_we   = !fifo_empty;
    assign fb.fb_addr = fifo_empty ? '0 : ADDR_WIDTH'(head.addr);
    assign fb.fb_data = fifo_empty ? '0 : COLOR_WIDTH'(head.color);
    assign pop        = fb.fb_we && fb.fb_ready;

    // The in-flight input-stage pixel counts toward occupancy: two more may still arrive.
    assign occ    = fifo_count + CW'(s1_vld);
    assign pix.oe = (state == ACCEPT) && (occ <= CW'(FIFO_DEPTH - 3));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = ACCEPT;
            ACCEPT: begin
                busy = 1'b1;
                if (pix.done_in) state_nxt = DRAIN;
            end
            DRAIN:  begin
                busy = 1'b1;
                if (fifo_empty && !s1_vld) state_nxt = DONE;
            end
            DONE:   begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef PIXEL_STATS_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stat_written <= '0;
            stat_clipped <= '0;
            stat_stall   <= '0;
        end else if (start_acc) begin
            stat_written <= '0;
            stat_clipped <= '0;
            stat_stall   <= '0;
        end else begin
            if (pop)                      stat_written <= sat_inc(stat_written);
            if (take && !in_range)        stat_clipped <= sat_inc(stat_clipped);
            if (fb.fb_we && !fb.fb_ready) stat_stall   <= sat_inc(stat_stall);
        end
    end
`endif

endmodule

// File: tb/tb_pixel_stream_writer.sv
// Directed bench for pixel_stream_writer: timing, clipping, flow control, reset and a small triangle.
module tb_pixel_stream_writer;
    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] color = 8'h00;
    logic       busy;
    logic       done;
`ifdef PIXEL_STATS_EN
    logic [31:0] st_w, st_c, st_s;
`endif

    pixel_stream_if #(.COORD_WIDTH(16)) pix ();
    fb_write_if #(.ADDR_WIDTH(16), .COLOR_WIDTH(8)) fbi ();

    pixel_stream_writer dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .start    (start),
        .color_in (color),
        .pix      (pix),
        .fb       (fbi),
        .busy     (busy),
        .done     (done)
`ifdef PIXEL_STATS_EN
        ,
        .stat_written (st_w),
        .stat_clipped (st_c),
        .stat_stall   (st_s)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int wr_addr[$];
    int wr_data[$];
    int last_wr_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int px[$];
    int py[$];

    always @(posedge clk) begin
        cyc++;
        if (fbi.fb_we && fbi.fb_ready) begin
            wr_addr.push_back(int'(fbi.fb_addr));
            wr_data.push_back(int'(fbi.fb_data));
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit inr(input int x, input int y);
        return (x >= 0) && (x < 320) && (y >= 0) && (y < 180);
    endfunction

    // Producer sees oe two cycles late (worst-case slack); mode 0: ready=1, 1: ready after 50 cycles, 2: toggling.
    task automatic run_prim(input logic [7:0] col, input int mode, input string tag);
        int n, idx, sent, wr0, dc0, oe_bad, occ, occ_max, k, bad;
        bit h1, h2, acc, got_done, exp_oe;
        int exp_a[$];
        n = px.size(); idx = 0; sent = 0; wr0 = wr_addr.size(); dc0 = done_cnt;
        oe_bad = 0; occ_max = 0; k = 0; bad = 0;
        h1 = 0; h2 = 0; acc = 1; got_done = 0;
        color = col; start = 1'b1;
        tick;
        start = 1'b0;
        while (!got_done && k < 3000) begin
            occ = sent - (wr_addr.size() - wr0);
            if (occ > occ_max) occ_max = occ;
            exp_oe = acc && (occ <= D - 3);
            if (pix.oe !== exp_oe) oe_bad++;
            if (done === 1'b1) got_done = 1;
            case (mode)
                0:       fbi.fb_ready = 1'b1;
                1:       fbi.fb_ready = (k >= 50);
                default: fbi.fb_ready = k[0];
            endcase
            pix.drawing_in = 1'b0;
            pix.done_in    = 1'b0;
            if (acc && h2 && idx < n) begin
                pix.x_in = 16'(px[idx]);
                pix.y_in = 16'(py[idx]);
                pix.drawing_in = 1'b1;
                if (inr(px[idx], py[idx])) begin
                    sent++;
                    exp_a.push_back(py[idx] * 320 + px[idx]);
                end
                idx++;
                if (idx == n) begin
                    pix.done_in = 1'b1;
                    acc = 0;
                end
            end else if (acc && n == 0) begin
                pix.done_in = 1'b1;
                acc = 0;
            end
            h2 = h1;
            h1 = pix.oe;
            tick;
            k++;
        end
        pix.drawing_in = 1'b0;
        pix.done_in    = 1'b0;
        fbi.fb_ready   = 1'b1;
        chk({tag, "_done_seen"}, got_done, 1);
        chk({tag, "_oe_model"}, oe_bad, 0);
        chk({tag, "_no_overflow"}, occ_max <= D, 1);
        chk({tag, "_busy_after"}, busy, 1'b0);
        chk({tag, "_done_once"}, done_cnt - dc0, 1);
        chk({tag, "_write_count"}, wr_addr.size() - wr0, sent);
        for (int i = 0; i < exp_a.size() && wr0 + i < wr_addr.size(); i++)
            if (wr_addr[wr0 + i] != exp_a[i] || wr_data[wr0 + i] != int'(col)) bad++;
        chk({tag, "_order_data"}, bad, 0);
        if (sent > 0) chk({tag, "_done_after_last_write"}, done_cyc > last_wr_cyc, 1);
    endtask

    initial begin
        int wr0, dc0;
        pix.x_in = '0; pix.y_in = '0; pix.drawing_in = 1'b0; pix.done_in = 1'b0;
        fbi.fb_ready = 1'b1;

        // Reset state
        repeat (3) tick;
        chk("rst_oe", pix.oe, 1'b0);
        chk("rst_fb_we", fbi.fb_we, 1'b0);
        chk("rst_fb_addr", fbi.fb_addr, 0);
        chk("rst_fb_data", fbi.fb_data, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;
        tick;

        // Single pixel (5,3) colour A5: write at +2, done two cycles after the write
        wr0 = wr_addr.size();
        color = 8'hA5; start = 1'b1;
        tick;
        start = 1'b0;
        chk("sp_busy", busy, 1'b1);
        chk("sp_oe", pix.oe, 1'b1);
        pix.x_in = 16'sd5; pix.y_in = 16'sd3; pix.drawing_in = 1'b1; pix.done_in = 1'b1;
        tick;
        pix.drawing_in = 1'b0; pix.done_in = 1'b0;
        chk("sp_we_t1", fbi.fb_we, 1'b0);
        chk("sp_oe_drain", pix.oe, 1'b0);
        tick;
        chk("sp_we_t2", fbi.fb_we, 1'b1);
        chk("sp_addr", fbi.fb_addr, 965);
        chk("sp_data", fbi.fb_data, 8'hA5);
        tick;
        chk("sp_we_t3", fbi.fb_we, 1'b0);
        chk("sp_done_t3", done, 1'b0);
        tick;
        chk("sp_done_t4", done, 1'b1);
        chk("sp_busy_t4", busy, 1'b0);
        tick;
        chk("sp_done_t5", done, 1'b0);
        chk("sp_wr_count", wr_addr.size() - wr0, 1);

        // Clipping
        px = '{-1, 320, 0, 319};
        py = '{0, 0, 180, 179};
        run_prim(8'h11, 0, "clip");
        chk("clip_addr", wr_addr[wr_addr.size() - 1], 57599);
`ifdef PIXEL_STATS_EN
        chk("clip_stat_clipped", st_c, 3);
        chk("clip_stat_written", st_w, 1);
`endif

        // Backpressure: 20-pixel burst with fb_ready low for the first 50 cycles
        px.delete(); py.delete();
        for (int i = 0; i < 20; i++) begin
            px.push_back(i * 3);
            py.push_back(1 + i);
        end
        run_prim(8'h3C, 1, "bp");

        // Zero-pixel primitive
        wr0 = wr_addr.size(); dc0 = done_cnt;
        start = 1'b1;
        tick;
        start = 1'b0; pix.done_in = 1'b1;
        tick;
        pix.done_in = 1'b0;
        chk("zp_done_c1", done, 1'b0);
        tick;
        chk("zp_done_c2", done, 1'b1);
        tick;
        chk("zp_done_c3", done, 1'b0);
        chk("zp_busy", busy, 1'b0);
        chk("zp_no_write", wr_addr.size() - wr0, 0);
        chk("zp_done_once", done_cnt - dc0, 1);

        // Async reset mid-drain with 5 entries queued
        wr0 = wr_addr.size();
        fbi.fb_ready = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            pix.x_in = 16'(i); pix.y_in = 16'sd1; pix.drawing_in = 1'b1;
            pix.done_in = (i == 5);
            tick;
        end
        pix.drawing_in = 1'b0; pix.done_in = 1'b0;
        tick;
        chk("ar_we_before", fbi.fb_we, 1'b1);
        chk("ar_busy_before", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_we_now", fbi.fb_we, 1'b0);
        chk("ar_busy_now", busy, 1'b0);
        chk("ar_addr_now", fbi.fb_addr, 0);
        #1 rst_n = 1'b1;
        fbi.fb_ready = 1'b1;
        tick;
        chk("ar_we_after", fbi.fb_we, 1'b0);
        chk("ar_no_write", wr_addr.size() - wr0, 0);
        px = '{7};
        py = '{2};
        run_prim(8'h5A, 0, "ar_next");
        chk("ar_next_addr", wr_addr[wr_addr.size() - 1], 647);

        // Triangle (0,0),(10,0),(0,10) with fb_ready toggling
        px.delete(); py.delete();
        for (int y = 0; y <= 10; y++)
            for (int x = 0; x <= 10 - y; x++) begin
                px.push_back(x);
                py.push_back(y);
            end
        run_prim(8'hC3, 2, "tri");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
